// File: rtl/itof_pipe.sv
// itof_pipe: three-stage pipelined XLEN-bit integer to IEEE-754 binary32 converter
// Ports: clk/rstn clock and async active-low reset; in_valid/in_ready/in_x/in_unsigned/
// in_rtz/in_tag issue side; out_valid/out_ready/out_res/out_inexact/out_tag result side.
module itof_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_x,
  input  logic             in_unsigned,
  input  logic             in_rtz,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic             out_inexact,
  output logic [TAG_W-1:0] out_tag
);
  localparam int LW = $clog2(XLEN);
  logic             adv;
  logic             s1_valid_q, s1_sign_q, s1_rtz_q;
  logic [XLEN-1:0]  s1_mag_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_sign_d;
  logic [XLEN-1:0]  s1_mag_d;
  logic             s2_valid_q, s2_sign_q, s2_rtz_q;
  logic [XLEN-1:0]  s2_norm_q;
  logic [7:0]       s2_e_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [LW-1:0]    lz;
  logic [XLEN-1:0]  s2_norm_d;
  logic [7:0]       s2_e_d;
  logic [22:0]      frac_t;
  logic             g, st, up, zero;
  logic [23:0]      frac_sum;
  logic [31:0]      res_d;
  logic             inexact_d;
  // whole pipe advances together; a stalled output freezes every stage
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign s1_sign_d = ~in_unsigned & in_x[XLEN-1];
  assign s1_mag_d  = s1_sign_d ? -in_x : in_x;
  // highest set bit wins because later iterations overwrite earlier ones
  always_comb begin
    lz = '0;
    for (int i = 0; i < XLEN; i++) lz = s1_mag_q[i] ? LW'(XLEN - 1 - i) : lz;
  end
  assign s2_norm_d = s1_mag_q << lz;
  assign s2_e_d    = 8'(XLEN - 1) - 8'(lz);
  // a normalised zero is the only value without its leading one set
  assign zero      = ~s2_norm_q[XLEN-1];
  assign frac_t    = s2_norm_q[XLEN-2 -: 23];
  assign g         = s2_norm_q[XLEN-25];
  assign st        = |s2_norm_q[XLEN-26:0];
  assign up        = ~s2_rtz_q & g & (st | frac_t[0]);
  assign frac_sum  = {1'b0, frac_t} + {23'd0, up};
  // a carry out leaves frac_sum[22:0] at zero, so only the exponent needs bumping
  assign res_d     = zero ? 32'h0 : {s2_sign_q, 8'd127 + s2_e_q + {7'd0, frac_sum[23]}, frac_sum[22:0]};
  assign inexact_d = ~zero & (g | st);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_rtz_q    <= 1'b0;
      s1_mag_q    <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_rtz_q    <= 1'b0;
      s2_norm_q   <= '0;
      s2_e_q      <= '0;
      s2_tag_q    <= '0;
      out_valid   <= 1'b0;
      out_res     <= '0;
      out_inexact <= 1'b0;
      out_tag     <= '0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s1_sign_q   <= s1_sign_d;
      s1_rtz_q    <= in_rtz;
      s1_mag_q    <= s1_mag_d;
      s1_tag_q    <= in_tag;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_rtz_q    <= s1_rtz_q;
      s2_norm_q   <= s2_norm_d;
      s2_e_q      <= s2_e_d;
      s2_tag_q    <= s1_tag_q;
      out_valid   <= s2_valid_q;
      out_res     <= res_d;
      out_inexact <= inexact_d;
      out_tag     <= s2_tag_q;
    end
  end
endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: directed self-checking bench for itof_pipe at XLEN 32 and 64
module tb_itof_pipe;
  logic        clk = 1'b0;
  logic        rstn;
  logic        a_valid, a_irdy, a_u, a_r, a_ovalid, a_ordy, a_inx;
  logic [31:0] a_x, a_res;
  logic [4:0]  a_tag, a_otag;
  logic        b_valid, b_irdy, b_u, b_r, b_ovalid, b_ordy, b_inx;
  logic [63:0] b_x;
  logic [31:0] b_res;
  logic [4:0]  b_tag, b_otag;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  itof_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rstn(rstn), .in_valid(a_valid), .in_ready(a_irdy), .in_x(a_x),
    .in_unsigned(a_u), .in_rtz(a_r), .in_tag(a_tag), .out_valid(a_ovalid),
    .out_ready(a_ordy), .out_res(a_res), .out_inexact(a_inx), .out_tag(a_otag)
  );
  itof_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rstn(rstn), .in_valid(b_valid), .in_ready(b_irdy), .in_x(b_x),
    .in_unsigned(b_u), .in_rtz(b_r), .in_tag(b_tag), .out_valid(b_ovalid),
    .out_ready(b_ordy), .out_res(b_res), .out_inexact(b_inx), .out_tag(b_otag)
  );

  // issues one operation into an idle pipe and waits (bounded) for its result;
  // lat counts negedges after the accept edge, -1 when nothing emerges
  task automatic run_op(input bit w64, input logic [63:0] x, input logic u, input logic r,
                        input logic [4:0] t, output logic [31:0] res, output logic inx,
                        output logic [4:0] ot, output int lat);
    @(negedge clk);
    a_ordy = 1'b1;
    b_ordy = 1'b1;
    if (w64) begin
      b_x = x; b_u = u; b_r = r; b_tag = t; b_valid = 1'b1;
    end else begin
      a_x = x[31:0]; a_u = u; a_r = r; a_tag = t; a_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    lat = -1;
    res = '0;
    inx = 1'b0;
    ot = '0;
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      @(negedge clk);
      if (w64 ? b_ovalid : a_ovalid) begin
        lat = n;
        res = w64 ? b_res : a_res;
        inx = w64 ? b_inx : a_inx;
        ot  = w64 ? b_otag : a_otag;
      end
    end
  endtask

  task automatic test_reset_state;
    #1;
    checks++;
    if (a_ovalid !== 1'b0 || a_res !== 32'h0 || a_inx !== 1'b0 || a_otag !== 5'd0 || a_irdy !== 1'b1) begin
      errors++;
      $display("FAIL reset32 got v=%b res=%h inx=%b tag=%0d rdy=%b want v=0 res=0 inx=0 tag=0 rdy=1",
               a_ovalid, a_res, a_inx, a_otag, a_irdy);
    end
    checks++;
    if (b_ovalid !== 1'b0 || b_res !== 32'h0 || b_inx !== 1'b0 || b_otag !== 5'd0 || b_irdy !== 1'b1) begin
      errors++;
      $display("FAIL reset64 got v=%b res=%h inx=%b tag=%0d rdy=%b want v=0 res=0 inx=0 tag=0 rdy=1",
               b_ovalid, b_res, b_inx, b_otag, b_irdy);
    end
  endtask

  task automatic test_conv32;
    logic [31:0] vx[13] = '{32'h1, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h01000001, 32'h01000003,
                            32'h01000003, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0,
                            32'h80000000, 32'h5};
    logic        vu[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    logic        vr[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1};
    logic [31:0] ve[13] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000, 32'h4B800000,
                            32'h4B800002, 32'h4B800001, 32'h4F800000, 32'h4F7FFFFF, 32'h4F000000,
                            32'h00000000, 32'h4F000000, 32'h40A00000};
    logic        vi[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [31:0] res;
    logic        inx;
    logic [4:0]  ot;
    int          lat;
    for (int i = 0; i < 13; i++) begin
      run_op(1'b0, {32'd0, vx[i]}, vu[i], vr[i], 5'(i + 3), res, inx, ot, lat);
      checks++;
      if (res !== ve[i] || inx !== vi[i]) begin
        errors++;
        $display("FAIL conv32[%0d] x=%h u=%b rtz=%b got %h inx=%b want %h inx=%b",
                 i, vx[i], vu[i], vr[i], res, inx, ve[i], vi[i]);
      end
      checks++;
      if (ot !== 5'(i + 3) || lat !== 3) begin
        errors++;
        $display("FAIL conv32_tag_lat[%0d] got tag=%0d lat=%0d want tag=%0d lat=3", i, ot, lat, i + 3);
      end
    end
  endtask

  task automatic test_conv64;
    logic [63:0] vx[5] = '{64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'h0000000000FFFFFF,
                           64'hFFFFFFFFFFFFFFFF, 64'h0};
    logic        vu[5] = '{1, 0, 0, 0, 0};
    logic [31:0] ve[5] = '{32'h5F800000, 32'hDF000000, 32'h4B7FFFFF, 32'hBF800000, 32'h0};
    logic        vi[5] = '{1, 0, 0, 0, 0};
    logic [31:0] res;
    logic        inx;
    logic [4:0]  ot;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, vx[i], vu[i], 1'b0, 5'(i + 20), res, inx, ot, lat);
      checks++;
      if (res !== ve[i] || inx !== vi[i]) begin
        errors++;
        $display("FAIL conv64[%0d] x=%h u=%b got %h inx=%b want %h inx=%b", i, vx[i], vu[i], res, inx, ve[i], vi[i]);
      end
      checks++;
      if (ot !== 5'(i + 20) || lat !== 3) begin
        errors++;
        $display("FAIL conv64_tag_lat[%0d] got tag=%0d lat=%0d want tag=%0d lat=3", i, ot, lat, i + 20);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] xs[6] = '{32'h1, 32'hFFFFFFFF, 32'h01000001, 32'h2, 32'h7FFFFFFF, 32'h3};
    logic [31:0] es[6] = '{32'h3F800000, 32'hBF800000, 32'h4B800000, 32'h40000000, 32'h4F000000, 32'h40400000};
    logic        ei[6] = '{0, 0, 1, 0, 1, 0};
    int          sent = 0;
    int          rcv = 0;
    logic        stalled = 1'b0;
    logic [31:0] p_res = '0;
    logic [4:0]  p_tag = '0;
    logic        p_inx = 1'b0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      @(negedge clk);
      a_ordy  = !(cyc >= 4 && cyc < 9);
      a_valid = sent < 6;
      a_u     = 1'b0;
      a_r     = 1'b0;
      if (sent < 6) begin
        a_x   = xs[sent];
        a_tag = 5'(sent + 1);
      end
      #1;
      checks++;
      if (a_irdy !== (~a_ovalid | a_ordy)) begin
        errors++;
        $display("FAIL b2b_ready cyc=%0d got %b want %b", cyc, a_irdy, ~a_ovalid | a_ordy);
      end
      if (stalled) begin
        checks++;
        if (a_ovalid !== 1'b1 || a_res !== p_res || a_otag !== p_tag || a_inx !== p_inx) begin
          errors++;
          $display("FAIL b2b_stable cyc=%0d got v=%b %h tag=%0d inx=%b want v=1 %h tag=%0d inx=%b",
                   cyc, a_ovalid, a_res, a_otag, a_inx, p_res, p_tag, p_inx);
        end
      end
      if (a_ovalid && a_ordy) begin
        checks++;
        if (a_res !== es[rcv] || a_otag !== 5'(rcv + 1) || a_inx !== ei[rcv]) begin
          errors++;
          $display("FAIL b2b_out[%0d] got %h tag=%0d inx=%b want %h tag=%0d inx=%b",
                   rcv, a_res, a_otag, a_inx, es[rcv], rcv + 1, ei[rcv]);
        end
        rcv++;
      end
      stalled = a_ovalid & ~a_ordy;
      p_res = a_res;
      p_tag = a_otag;
      p_inx = a_inx;
      if (a_valid && a_irdy) sent++;
    end
    @(negedge clk);
    a_valid = 1'b0;
    a_ordy  = 1'b1;
    checks++;
    if (rcv !== 6) begin
      errors++;
      $display("FAIL b2b_count got %0d want 6", rcv);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (a_ovalid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_extra cyc=%0d got out_valid=%b want 0", k, a_ovalid);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    logic        inx;
    logic [4:0]  ot;
    int          lat;
    a_ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_valid = 1'b1;
      a_x     = 32'(k + 1);
      a_tag   = 5'(k + 10);
      a_u     = 1'b0;
      a_r     = 1'b0;
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    rstn    = 1'b0;
    #1;
    checks++;
    if (a_ovalid !== 1'b0 || a_res !== 32'h0 || a_irdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async got v=%b res=%h rdy=%b want v=0 res=0 rdy=1", a_ovalid, a_res, a_irdy);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (a_ovalid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_hold cyc=%0d got out_valid=%b want 0", k, a_ovalid);
      end
    end
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (a_ovalid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_ghost cyc=%0d got out_valid=%b want 0", k, a_ovalid);
      end
    end
    run_op(1'b0, 64'd5, 1'b0, 1'b0, 5'd17, res, inx, ot, lat);
    checks++;
    if (res !== 32'h40A00000 || ot !== 5'd17 || lat !== 3 || inx !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_next got %h tag=%0d lat=%0d inx=%b want 40a00000 tag=17 lat=3 inx=0",
               res, ot, lat, inx);
    end
  endtask

  initial begin
    rstn = 1'b0;
    a_valid = 1'b0; a_x = '0; a_u = 1'b0; a_r = 1'b0; a_tag = '0; a_ordy = 1'b1;
    b_valid = 1'b0; b_x = '0; b_u = 1'b0; b_r = 1'b0; b_tag = '0; b_ordy = 1'b1;
    #12;
    test_reset_state();
    @(negedge clk);
    rstn = 1'b1;
    test_conv32();
    test_conv64();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/itof_pipe.md
# itof_pipe

Pipelined, parametrised integer-to-single-precision converter for the FPU. It accepts XLEN-bit signed or unsigned integers and produces IEEE-754 binary32 results. Rounding is selectable per operation: round-to-nearest-even or round-toward-zero. It has a valid/ready handshake, an opaque tag carried alongside each operation, and an inexact flag. It replaces the single-cycle, half-up-rounding conversion path in the FPU execute stage. The result is three registered stages behind the issue port, so it meets timing at 64-bit input width.

## Interface
- XLEN, 32: input integer width; legal values 32 or 64.
- TAG_W, 5: width of the pass-through tag (typically the destination register index); must be at least 1.

- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  operation present on the input.
- in_ready  out  1  converter accepts the operation this cycle.
- in_x  in  XLEN  integer operand.
- in_unsigned  in  1  1: treat in_x as unsigned; 0: two's complement.
- in_rtz  in  1  1: round toward zero; 0: round to nearest, ties to even.
- in_tag  in  TAG_W  opaque, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_res  out  32  binary32 result {sign, exp[7:0], frac[22:0]}.
- out_inexact  out  1  1 when any nonzero bit was discarded by rounding.
- out_tag  out  TAG_W  tag of the result.

## Operation
- **Stage S1 (register on accept).**
  - sign = ~in_unsigned & in_x[XLEN-1].
  - mag = sign ? -in_x : in_x. The magnitude is XLEN bits unsigned; -2^(XLEN-1) gives mag = 2^(XLEN-1) with no overflow.
  - zero = (in_x == 0).
  - The rtz and tag bits are registered alongside.
- **Stage S2.**
  - lz = leading-zero count of mag, clog2(XLEN) bits.
  - norm = mag << lz, so norm[XLEN-1] = 1 unless zero.
  - e_unb = XLEN-1-lz.
- **Stage S3 (rounding, output register).**
  - frac_t = norm[XLEN-2 -: 23].
  - g = norm[XLEN-25].
  - st = |norm[XLEN-26:0].
  - Round-up decision:
    - RNE: up = g & (st | frac_t[0]).
    - RTZ: up = 0.
  - frac = frac_t + up. If this carries out of 23 bits, frac becomes 0 and the exponent is incremented.
  - exp = 127 + e_unb + carry. It never exceeds 127+64, so there is no overflow or infinity case.
  - inexact = g | st.
  - If zero: out_res = 32'h0000_0000 and inexact = 0. The sign is forced to 0, so there is never a -0.
- **Exactness.** Magnitudes below 2^24 are always exact.
- **Width handling.** For XLEN = 32, the bits below the guard bit are norm[6:0].

## Timing
- Latency: 3 cycles from the accept edge to out_valid, with no back-pressure.
- Throughput: 1 per cycle.
- **Handshake.**
  - Transfer on the input when in_valid & in_ready; on the output when out_valid & out_ready.
  - out_res, out_tag and out_inexact stay stable while out_valid & ~out_ready.
- **Global stall.**
  - adv = ~out_valid | out_ready.
  - in_ready = adv, combinational from out_ready and out_valid only, never from in_valid.
  - All three stages (data and valid bits) move only when adv = 1.
  - Bubbles are not collapsed while stalled.
- **Reset.**
  - rstn low at any time clears the S1, S2 and S3 valid bits immediately.
  - Reset values: out_valid = 0, out_res = 0, out_inexact = 0, out_tag = 0, in_ready = 1.
  - In-flight operations are dropped. No handshake completes while rstn is low.
- **Simultaneous events.** An output drain and an input accept in the same cycle are the normal full-throughput case. Both occur, and the pipeline shifts by one.
- Operations leave in accept order.

## Test plan
- **Basic signed values, RNE.** 1 -> 0x3F800000; -1 -> 0xBF800000; 0 -> 0x00000000 with inexact 0; -2^31 -> 0xCF000000 with inexact 0.
- **Ties and width boundaries.**
  - XLEN=32, RNE, 0x01000001 -> 0x4B800000 (tie to even, inexact 1).
  - XLEN=32, RNE, 0x01000003 -> 0x4B800002 (inexact 1).
  - XLEN=32, RTZ, 0x01000003 -> 0x4B800001.
- **Carry into exponent and unsigned mode.**
  - Unsigned 0xFFFFFFFF: RNE -> 0x4F800000; RTZ -> 0x4F7FFFFF.
  - Signed 0x7FFFFFFF, RNE -> 0x4F000000.
  - Signed 0xFFFFFFFF -> 0xBF800000.
- **XLEN=64.**
  - Unsigned 2^64-1, RNE -> 0x5F800000.
  - Signed -2^63 -> 0xDF000000.
  - 0x0000000000FFFFFF -> 0x4B7FFFFF, exact.
- **Back-pressure.**
  - Stimulus: stream 6 tagged operations with in_valid held high, hold out_ready low for 5 cycles mid-stream, then release.
  - Required: in_ready low exactly while out_valid & ~out_ready; all 6 results delivered in order with correct tags; outputs stable during the stall; no duplicates.
- **Reset mid-operation.**
  - Stimulus: pull rstn low while 3 operations are in flight.
  - Required: out_valid is 0 during reset; nothing from those operations appears after release; the next accepted operation emerges 3 cycles after its accept.
